hrm_outbox_fifo: RTL and testbench
==================================

Name: hrm_outbox_fifo

Overview:
- Output queue of the HRM CPU. It sits directly downstream of the control unit's OUTBOX state.
- Captures the 8-bit R register value on each `i_wO` pulse and reports `o_full` back to the control unit as its `outFull` input.
- Drains entries to the output consumer (display/UART shim) over a valid/ready stream.
- First-word-fall-through FIFO with occupancy count, synchronous clear and full/empty status.

Parameters:
- DATA_W, 8, width of one queued word (R register width).
- DEPTH_LOG2, 5, log2 of entry count; depth = 2**DEPTH_LOG2 = 32.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_clr  in  1  synchronous flush, active-high (driven during CPU soft reset).
- i_data  in  DATA_W  word to enqueue (R register output).
- i_wO  in  1  enqueue strobe from control unit (wO), single-cycle.
- o_full  out  1  queue full; wired to control unit outFull.
- o_empty  out  1  queue empty.
- o_count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- o_valid  out  1  head word available to consumer.
- o_data  out  DATA_W  head word; meaningful only while o_valid=1.
- i_ready  in  1  consumer accepts head word this cycle.

Behaviour:
- Storage: 2**DEPTH_LOG2 x DATA_W array; write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth; count is a separate DEPTH_LOG2+1-bit register.
- Reset (i_rst_n=0, async): wr_ptr=0, rd_ptr=0, count=0. Outputs: o_full=0, o_empty=1, o_count=0, o_valid=0, o_data=0. Array contents are not reset.
- Status outputs are combinational from count: o_full = (count == 2**DEPTH_LOG2), o_empty = (count == 0), o_valid = !o_empty.
- o_data = mem[rd_ptr], combinational read (FWFT).
- Write accepted when i_wO=1 and o_full=0: mem[wr_ptr]<=i_data, wr_ptr+1.
- Write with o_full=1 is dropped: no state change, even if a read happens the same cycle.
- Read accepted when i_ready=1 and o_valid=1: rd_ptr+1. i_ready while empty is ignored.
- Count update: +1 on write only; -1 on read only; unchanged when both or neither occur.
- Latency: word written at edge N appears on o_data with o_valid=1 after edge N when the queue was empty (one-cycle write-to-valid); o_full asserts in the cycle following the filling write.
- Simultaneous write and read with count=0: the write is accepted, the read is ignored, and count becomes 1.
- i_clr=1: pointers and count return to 0 at the next edge and override any simultaneous write/read. Array is untouched.
- Reset mid-operation: queue is emptied immediately; o_valid drops asynchronously.
- Control-unit contract: DECODE samples o_full and the OUTBOX state pulses i_wO one cycle later. The queue therefore has only one writer and no write race.
- Ordering: strict FIFO; no reordering, no duplication.

Optional Feature:
- Macro: OUTBOX_OVERFLOW_EN.
- Defined:
  - Adds output o_ovf (1 bit), sticky overflow flag.
  - o_ovf is set on the edge where i_wO=1 while o_full=1.
  - It is cleared only by i_rst_n=0 or i_clr=1; i_clr has priority over a same-cycle set.
  - Reset value 0.
- Undefined: port o_ovf is absent and dropped writes leave no trace; all other behaviour is identical.

Test Plan:
- Reset then idle -> o_empty=1, o_full=0, o_count=0, o_valid=0, o_data=0.
- Write 0x2A with i_ready=0 -> next cycle o_valid=1, o_data=0x2A, o_count=1; pulse i_ready -> o_empty=1, o_count=0.
- 32 writes 0x00..0x1F, i_ready=0 -> o_full=1, o_count=32. 33rd write 0xFF is dropped (o_ovf=1 if OUTBOX_OVERFLOW_EN). Then drain: reads 0x00..0x1F in order, with no 0xFF.
- Wrap-around: fill 20, drain 20, fill 20 more values 0x40..0x53 -> all read back in order, o_count tracks 20→0.
- Count 5, i_wO=1 and i_ready=1 in the same cycle -> o_count stays 5, head advances, new word lands at the tail. Count 0 with both asserted -> o_count=1 and the new word is at the head.
- i_clr=1 with count 7 plus a simultaneous write -> o_count=0, o_empty=1 next cycle. Async i_rst_n low mid-drain -> o_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/hrm_outbox_fifo.sv
// hrm_outbox_fifo: FWFT output queue for the HRM CPU OUTBOX with count and full/empty status.
// Define OUTBOX_OVERFLOW_EN to add the sticky o_ovf flag for dropped writes.
module hrm_outbox_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_wO,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_data,
  input  logic                  i_ready
`ifdef OUTBOX_OVERFLOW_EN
  ,
  output logic                  o_ovf
`endif
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2 + 1)'(1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] count;
  logic wr, rd;
  assign o_full  = count == FULL;
  assign o_empty = count == '0;
  assign o_valid = !o_empty;
  assign o_count = count;
  // Head is masked while empty so stale array contents never leak out after reset.
  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  assign wr = i_wO && !o_full;
  assign rd = i_ready && o_valid;
  always_ff @(posedge clk)
    if (wr && !i_clr) mem[wr_ptr] <= i_data;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + DEPTH_LOG2'(1) : wr_ptr;
      rd_ptr <= rd ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
      count  <= (wr && !rd) ? count + ONE : (rd && !wr) ? count - ONE : count;
    end
`ifdef OUTBOX_OVERFLOW_EN
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) o_ovf <= 1'b0;
    else if (i_clr) o_ovf <= 1'b0;
    else if (i_wO && o_full) o_ovf <= 1'b1;
`endif
endmodule

// File: tb/tb_hrm_outbox_fifo.sv
// tb_hrm_outbox_fifo: directed scoreboard bench for hrm_outbox_fifo (honours OUTBOX_OVERFLOW_EN).
module tb_hrm_outbox_fifo;
  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_clr = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_wO = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_full, o_empty, o_valid;
  logic [5:0] o_count;
  logic [7:0] o_data;
`ifdef OUTBOX_OVERFLOW_EN
  logic       o_ovf;
  logic       ovf_exp = 1'b0;
`endif
  logic [7:0] sb[$];
  int         mcount = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  hrm_outbox_fifo #(.DATA_W(8), .DEPTH_LOG2(5)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_data(i_data), .i_wO(i_wO),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count), .o_valid(o_valid),
    .o_data(o_data), .i_ready(i_ready)
`ifdef OUTBOX_OVERFLOW_EN
    , .o_ovf(o_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag);
    chk({tag, ".count"}, 32'(o_count), 32'(mcount));
    chk({tag, ".empty"}, 32'(o_empty), 32'(mcount == 0));
    chk({tag, ".full"}, 32'(o_full), 32'(mcount == 32));
    chk({tag, ".valid"}, 32'(o_valid), 32'(mcount != 0));
    if (mcount != 0) chk({tag, ".head"}, 32'(o_data), 32'(sb[0]));
`ifdef OUTBOX_OVERFLOW_EN
    chk({tag, ".ovf"}, 32'(o_ovf), 32'(ovf_exp));
`endif
  endtask

  // One clock with optional write/read; the model decides what is accepted.
  task automatic xfer(input logic w, input logic r, input logic [7:0] d, input string tag);
    logic wa, ra;
    logic [7:0] got;
    wa = w && mcount < 32;
    ra = r && mcount > 0;
    if (ra) begin
      got = sb.pop_front();
      chk({tag, ".pop"}, 32'(o_data), 32'(got));
    end
    if (wa) sb.push_back(d);
`ifdef OUTBOX_OVERFLOW_EN
    if (w && mcount == 32) ovf_exp = 1'b1;
`endif
    mcount = mcount + int'(wa) - int'(ra);
    i_wO = w; i_ready = r; i_data = d;
    @(posedge clk); #1;
    i_wO = 1'b0; i_ready = 1'b0;
    status(tag);
  endtask

  initial begin
    #1;
    chk("rst.count", 32'(o_count), 0);
    chk("rst.empty", 32'(o_empty), 1);
    chk("rst.full", 32'(o_full), 0);
    chk("rst.valid", 32'(o_valid), 0);
    chk("rst.data", 32'(o_data), 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    status("idle");
    xfer(1'b0, 1'b1, 8'h00, "rd_empty");
    xfer(1'b1, 1'b0, 8'h2A, "wr2a");
    xfer(1'b0, 1'b1, 8'h00, "rd2a");
    for (int i = 0; i < 32; i++) xfer(1'b1, 1'b0, 8'(i), "fill32");
    xfer(1'b1, 1'b0, 8'hFF, "drop_ff");
    xfer(1'b1, 1'b1, 8'hFE, "drop_rw");
    for (int i = 0; i < 31; i++) xfer(1'b0, 1'b1, 8'h00, "drain32");
    for (int i = 0; i < 20; i++) xfer(1'b1, 1'b0, 8'h80 + 8'(i), "wrapfill_a");
    for (int i = 0; i < 20; i++) xfer(1'b0, 1'b1, 8'h00, "wrapdrain_a");
    for (int i = 0; i < 20; i++) xfer(1'b1, 1'b0, 8'h40 + 8'(i), "wrapfill_b");
    for (int i = 0; i < 20; i++) xfer(1'b0, 1'b1, 8'h00, "wrapdrain_b");
    for (int i = 0; i < 5; i++) xfer(1'b1, 1'b0, 8'h10 + 8'(i), "fill5");
    xfer(1'b1, 1'b1, 8'h77, "both5");
    for (int i = 0; i < 5; i++) xfer(1'b0, 1'b1, 8'h00, "drain5");
    xfer(1'b1, 1'b1, 8'h99, "both0");
    xfer(1'b0, 1'b1, 8'h00, "drain99");
    for (int i = 0; i < 7; i++) xfer(1'b1, 1'b0, 8'h60 + 8'(i), "fill7");
    i_clr = 1'b1; i_wO = 1'b1; i_ready = 1'b1; i_data = 8'hC3;
    @(posedge clk); #1;
    i_clr = 1'b0; i_wO = 1'b0; i_ready = 1'b0;
    sb.delete(); mcount = 0;
`ifdef OUTBOX_OVERFLOW_EN
    ovf_exp = 1'b0;
`endif
    status("clr");
    xfer(1'b1, 1'b0, 8'h5A, "postclr");
    xfer(1'b1, 1'b0, 8'h5B, "postclr");
    xfer(1'b0, 1'b1, 8'h00, "middrain");
    i_ready = 1'b1;
    #3 i_rst_n = 1'b0;
    #1;
    chk("async.valid", 32'(o_valid), 0);
    chk("async.count", 32'(o_count), 0);
    chk("async.empty", 32'(o_empty), 1);
    chk("async.data", 32'(o_data), 0);
    i_ready = 1'b0;
    sb.delete(); mcount = 0;
`ifdef OUTBOX_OVERFLOW_EN
    ovf_exp = 1'b0;
`endif
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    status("afterrst");
    xfer(1'b1, 1'b0, 8'hE1, "final");
    xfer(1'b0, 1'b1, 8'h00, "final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
